// File: rtl/cache_pkg.sv
// Shared encodings for the L1 request controller: MESI states, snoop-bus
// request/response codes, CPU response codes and the controller FSM states.
package cache_pkg;

  localparam int unsigned MESI_W  = 3;
  localparam int unsigned SDREQ_W = 3;
  localparam int unsigned SURSP_W = 3;
  localparam int unsigned CURSP_W = 2;

  localparam logic [MESI_W-1:0] INVALID   = 3'd0;
  localparam logic [MESI_W-1:0] SHARED    = 3'd1;
  localparam logic [MESI_W-1:0] EXCLUSIVE = 3'd2;
  localparam logic [MESI_W-1:0] MODIFIED  = 3'd3;

  localparam logic [SDREQ_W-1:0] SDREQ_RD  = 3'd0;
  localparam logic [SDREQ_W-1:0] SDREQ_RFO = 3'd1;
  localparam logic [SDREQ_W-1:0] SDREQ_INV = 3'd2;
  localparam logic [SDREQ_W-1:0] SDREQ_WB  = 3'd3;

  localparam logic [SURSP_W-1:0] SURSP_SNOOP = 3'd0;
  localparam logic [SURSP_W-1:0] SURSP_FETCH = 3'd1;
  localparam logic [SURSP_W-1:0] SURSP_OKAY  = 3'd2;

  localparam logic [CURSP_W-1:0] CURSP_OKAY = 2'd0;
  localparam logic [CURSP_W-1:0] CURSP_ERR  = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WB_REQ,
    ST_SD_REQ,
    ST_WAIT_SURSP,
    ST_UPDATE,
    ST_SEND_RSP
  } l1_req_st_e;

endpackage

// File: rtl/l1_req_timeout_cnt.sv
// Wait-cycle counter: clears while idle, counts while enabled and flags the
// last permitted cycle (count == LIMIT-1).
module l1_req_timeout_cnt #(
  parameter int unsigned LIMIT     = 256,
  parameter int unsigned CNT_WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [CNT_WIDTH-1:0] cnt;

  assign expire_c = (cnt == CNT_WIDTH'(LIMIT - 1));

  // Saturates at the expiry value so a stalled owner never wraps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire_c) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/l1_req_ctrl_seq.sv
// L1 request controller: classifies one CPU request at a time, issues snoop
// requests (write-back of a dirty victim first), waits for the snoop
// response with timeout, commits the MESI next state and answers the CPU.
module l1_req_ctrl_seq
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned CNT_WIDTH   = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic                  lkup_hit,
  input  logic [2:0]            lkup_blk_st,
  output logic                  sdreq_valid,
  input  logic                  sdreq_ready,
  output logic [2:0]            sdreq_type,
  output logic [ADDR_WIDTH-1:0] sdreq_addr,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  input  logic                  sursp_valid,
  input  logic [2:0]            sursp_rsp,
  output logic                  blk_upd_valid,
  output logic [2:0]            blk_nxtSt,
  output logic                  cursp_valid,
  input  logic                  cursp_ready,
  output logic [1:0]            cursp_rsp
);

  l1_req_st_e            state, state_d;
  logic [ADDR_WIDTH-1:0] req_addr, req_addr_d;
  logic                  req_wr, req_wr_d;
  logic                  refill, refill_d;
  logic [2:0]            sdreq_type_d;
  logic [ADDR_WIDTH-1:0] sdreq_addr_d;
  logic [2:0]            nxt_st_d;
  logic [1:0]            cursp_rsp_d;
  logic                  expire_c;
  logic [2:0]            miss_type_c;

  assign miss_type_c = req_wr ? SDREQ_RFO : SDREQ_RD;

  l1_req_timeout_cnt #(
    .LIMIT     (TIMEOUT_CYC),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state != ST_WAIT_SURSP),
    .en       (state == ST_WAIT_SURSP),
    .expire_c (expire_c)
  );

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_d      = state;
    req_addr_d   = req_addr;
    req_wr_d     = req_wr;
    refill_d     = refill;
    sdreq_type_d = sdreq_type;
    sdreq_addr_d = sdreq_addr;
    nxt_st_d     = blk_nxtSt;
    cursp_rsp_d  = cursp_rsp;

    unique case (state)
      ST_IDLE: begin
        if (cpu_req_valid) begin
          state_d    = ST_CHECK;
          req_addr_d = cpu_req_addr;
          req_wr_d   = cpu_req_wr;
          refill_d   = 1'b0;
        end
      end

      ST_CHECK: begin
        if (lkup_hit && !req_wr) begin
          state_d  = ST_UPDATE;
          nxt_st_d = lkup_blk_st;
        end else if (lkup_hit && (lkup_blk_st == MODIFIED || lkup_blk_st == EXCLUSIVE)) begin
          state_d  = ST_UPDATE;
          nxt_st_d = MODIFIED;
        end else if (lkup_hit && lkup_blk_st == SHARED) begin
          state_d      = ST_SD_REQ;
          sdreq_type_d = SDREQ_INV;
          sdreq_addr_d = req_addr;
        end else if (lkup_blk_st == MODIFIED) begin
          state_d      = ST_WB_REQ;
          sdreq_type_d = SDREQ_WB;
          sdreq_addr_d = victim_addr;
        end else begin
          state_d      = ST_SD_REQ;
          sdreq_type_d = miss_type_c;
          sdreq_addr_d = req_addr;
        end
      end

      ST_WB_REQ: begin
        if (sdreq_ready) begin
          state_d  = ST_WAIT_SURSP;
          refill_d = 1'b1;
        end
      end

      ST_SD_REQ: begin
        if (sdreq_ready) begin
          state_d = ST_WAIT_SURSP;
        end
      end

      ST_WAIT_SURSP: begin
        if (sursp_valid) begin
          if (refill) begin
            refill_d     = 1'b0;
            state_d      = ST_SD_REQ;
            sdreq_type_d = miss_type_c;
            sdreq_addr_d = req_addr;
          end else if (sdreq_type == SDREQ_INV || sdreq_type == SDREQ_RFO) begin
            state_d  = ST_UPDATE;
            nxt_st_d = MODIFIED;
          end else if (sdreq_type == SDREQ_RD && sursp_rsp == SURSP_SNOOP) begin
            state_d  = ST_UPDATE;
            nxt_st_d = SHARED;
          end else if (sdreq_type == SDREQ_RD && sursp_rsp == SURSP_FETCH) begin
            state_d  = ST_UPDATE;
            nxt_st_d = EXCLUSIVE;
          end else begin
            // SURSP_OKAY or any unknown code on a read is a protocol error.
            state_d     = ST_SEND_RSP;
            cursp_rsp_d = CURSP_ERR;
          end
        end else if (expire_c) begin
          state_d     = ST_SEND_RSP;
          cursp_rsp_d = CURSP_ERR;
        end
      end

      ST_UPDATE: begin
        state_d     = ST_SEND_RSP;
        cursp_rsp_d = CURSP_OKAY;
      end

      ST_SEND_RSP: begin
        if (cursp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_addr <= '0;
      req_wr   <= 1'b0;
      refill   <= 1'b0;
    end else begin
      state    <= state_d;
      req_addr <= req_addr_d;
      req_wr   <= req_wr_d;
      refill   <= refill_d;
    end
  end

  // Output registers track the state being entered so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_req_ready <= 1'b1;
      sdreq_valid   <= 1'b0;
      sdreq_type    <= SDREQ_RD;
      sdreq_addr    <= '0;
      blk_upd_valid <= 1'b0;
      blk_nxtSt     <= INVALID;
      cursp_valid   <= 1'b0;
      cursp_rsp     <= CURSP_OKAY;
    end else begin
      cpu_req_ready <= (state_d == ST_IDLE);
      sdreq_valid   <= (state_d == ST_WB_REQ) || (state_d == ST_SD_REQ);
      sdreq_type    <= sdreq_type_d;
      sdreq_addr    <= sdreq_addr_d;
      blk_upd_valid <= (state_d == ST_UPDATE);
      blk_nxtSt     <= nxt_st_d;
      cursp_valid   <= (state_d == ST_SEND_RSP);
      cursp_rsp     <= cursp_rsp_d;
    end
  end

endmodule
